stage2_sketch_multi: RTL

- Parametrised successor stage-2 sketch: ROWS-deep count-min frequency sketch plus per-row max-latency sketch.
- Counter and latency arrays are internal simple-dual-port RAMs.
- Adds valid/ready handshake, saturating counters, read-after-write forwarding for back-to-back keys, and a bulk clear engine.
- Sits after stage-1 filtering; feeds estimates to the report/query logic.

---
 rtl/stage2_sketch_multi.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/stage2_sketch_multi.sv
// Stage-2 count-min frequency sketch with per-row max-latency sketch.
// ROWS rows of 2^HW counters and latency maxima held in simple-dual-port RAMs,
// 3-cycle pipeline with valid/ready intake, read-after-write forwarding for
// back-to-back keys, saturating counters and a bulk clear engine.
// Optional build macro: SKETCH_CONSERVATIVE_EN (conservative counter update).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid_i/ready_o  request handshake
//   req_op_i             0 = insert, 1 = query
//   req_key_i, req_lat_i flow key, sample latency
//   clear_i, busy_o      clear request pulse, clear pending/sweeping
//   res_valid_o, res_op_o, res_freq_o, res_lat_o   one-cycle result strobe
module stage2_sketch_multi #(
    parameter int ROWS = 4,
    parameter int HW   = 10,
    parameter int KW   = 64,
    parameter int CW   = 32,
    parameter int LW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_op_i,
    input  logic [KW-1:0] req_key_i,
    input  logic [LW-1:0] req_lat_i,
    input  logic          clear_i,
    output logic          busy_o,
    output logic          res_valid_o,
    output logic          res_op_o,
    output logic [CW-1:0] res_freq_o,
    output logic [LW-1:0] res_lat_o
);
    localparam int DEPTH = 1 << HW;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam logic [HW-1:0] ALAST = HW'(DEPTH - 1);

    typedef enum logic [1:0] {CLR_IDLE, CLR_PEND, CLR_SWEEP} clr_state_t;

    function automatic logic [31:0] crc32(input logic [KW-1:0] k);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = KW - 1; i >= 0; i--) begin
            if (c[31] ^ k[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Rotate right by 7*r: low half of {h,h} shifted right.
    function automatic logic [HW-1:0] row_idx(input logic [31:0] h, input int r);
        return HW'({h, h} >> ((7 * r) % 32));
    endfunction

    logic [CW-1:0] cnt_mem [ROWS][DEPTH];
    logic [LW-1:0] lat_mem [ROWS][DEPTH];

    logic [31:0]   hash;
    logic [HW-1:0] idx_c  [ROWS];
    logic          s1_valid, s1_op, s2_valid, s2_op;
    logic [LW-1:0] s1_lat, s2_lat;
    logic [HW-1:0] s1_idx [ROWS];
    logic [HW-1:0] s2_idx [ROWS];
    logic [CW-1:0] rd_cnt [ROWS];
    logic [LW-1:0] rd_lat [ROWS];
    logic          fwd_valid;
    logic [HW-1:0] fwd_idx [ROWS];
    logic [CW-1:0] fwd_cnt [ROWS];
    logic [LW-1:0] fwd_lat [ROWS];
    logic [CW-1:0] cur_cnt [ROWS];
    logic [CW-1:0] new_cnt [ROWS];
    logic [LW-1:0] cur_lat [ROWS];
    logic [LW-1:0] new_lat [ROWS];
    logic [CW-1:0] min_cur, min_new;
    logic [LW-1:0] min_cur_lat, min_new_lat;
    clr_state_t    clr_state, clr_next;
    logic [HW-1:0] clr_addr;
    logic          pipe_empty, do_clr, accept, wr_en;

    assign pipe_empty  = !s1_valid && !s2_valid;
    assign accept      = req_valid_i && req_ready_o;
    assign wr_en       = s2_valid && !s2_op;

    // Clear controller: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state <= CLR_PEND;
            clr_addr  <= '0;
        end else begin
            clr_state <= clr_next;
            if (do_clr) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Clear controller: next state. The first sweep write happens in the
    // cycle the pipeline is seen empty, so the sweep lasts exactly 2^HW cycles.
    always_comb begin
        clr_next = clr_state;
        unique case (clr_state)
            CLR_IDLE:  if (clear_i) clr_next = CLR_PEND;
            CLR_PEND:  if (pipe_empty) clr_next = CLR_SWEEP;
            CLR_SWEEP: if (clr_addr == ALAST) clr_next = CLR_IDLE;
            default:   clr_next = CLR_IDLE;
        endcase
    end

    // Clear controller: outputs
    always_comb begin
        busy_o      = clr_state != CLR_IDLE;
        do_clr      = (clr_state == CLR_SWEEP) ||
                      (clr_state == CLR_PEND && pipe_empty);
        req_ready_o = !busy_o && !clear_i;
    end

    always_comb begin
        hash = crc32(req_key_i);
        for (int r = 0; r < ROWS; r++) idx_c[r] = row_idx(hash, r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_lat   <= '0;
            s2_valid <= 1'b0;
            s2_op    <= 1'b0;
            s2_lat   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                s1_idx[r] <= '0;
                s2_idx[r] <= '0;
            end
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op  <= req_op_i;
                s1_lat <= req_lat_i;
                for (int r = 0; r < ROWS; r++) s1_idx[r] <= idx_c[r];
            end
            s2_valid <= s1_valid;
            s2_op    <= s1_op;
            s2_lat   <= s1_lat;
            for (int r = 0; r < ROWS; r++) s2_idx[r] <= s1_idx[r];
        end
    end

    // Read-first RAMs; the clear sweep never overlaps an S2 write.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            rd_cnt[r] <= cnt_mem[r][s1_idx[r]];
            rd_lat[r] <= lat_mem[r][s1_idx[r]];
            if (do_clr) begin
                cnt_mem[r][clr_addr] <= '0;
                lat_mem[r][clr_addr] <= '0;
            end else if (wr_en) begin
                cnt_mem[r][s2_idx[r]] <= new_cnt[r];
                lat_mem[r][s2_idx[r]] <= new_lat[r];
            end
        end
    end

    // Last written row data, covering the read-first hole one request back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                fwd_idx[r] <= '0;
                fwd_cnt[r] <= '0;
                fwd_lat[r] <= '0;
            end
        end else begin
            fwd_valid <= wr_en;
            for (int r = 0; r < ROWS; r++) begin
                fwd_idx[r] <= s2_idx[r];
                fwd_cnt[r] <= new_cnt[r];
                fwd_lat[r] <= new_lat[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            if (fwd_valid && fwd_idx[r] == s2_idx[r]) begin
                cur_cnt[r] = fwd_cnt[r];
                cur_lat[r] = fwd_lat[r];
            end else begin
                cur_cnt[r] = rd_cnt[r];
                cur_lat[r] = rd_lat[r];
            end
        end
        min_cur     = cur_cnt[0];
        min_cur_lat = cur_lat[0];
        for (int r = 1; r < ROWS; r++) begin
            if (cur_cnt[r] < min_cur)     min_cur     = cur_cnt[r];
            if (cur_lat[r] < min_cur_lat) min_cur_lat = cur_lat[r];
        end
        for (int r = 0; r < ROWS; r++) begin
`ifdef SKETCH_CONSERVATIVE_EN
            if (cur_cnt[r] == min_cur && cur_cnt[r] != CMAX)
`else
            if (cur_cnt[r] != CMAX)
`endif
                new_cnt[r] = cur_cnt[r] + 1'b1;
            else
                new_cnt[r] = cur_cnt[r];
            new_lat[r] = (cur_lat[r] > s2_lat) ? cur_lat[r] : s2_lat;
        end
        min_new     = new_cnt[0];
        min_new_lat = new_lat[0];
        for (int r = 1; r < ROWS; r++) begin
            if (new_cnt[r] < min_new)     min_new     = new_cnt[r];
            if (new_lat[r] < min_new_lat) min_new_lat = new_lat[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_o <= 1'b0;
            res_op_o    <= 1'b0;
            res_freq_o  <= '0;
            res_lat_o   <= '0;
        end else begin
            res_valid_o <= s2_valid;
            if (s2_valid) begin
                res_op_o   <= s2_op;
                res_freq_o <= s2_op ? min_cur : min_new;
                res_lat_o  <= s2_op ? min_cur_lat : min_new_lat;
            end
        end
    end

endmodule
